access_arbiter_fsm: RTL and testbench
=====================================

Name: access_arbiter_fsm

Overview:
- Round-robin, time-limited arbiter that shares one controlled resource (gate/actuator channel) between two requesters.
- Sequences each grant through IDLE -> GRANT -> GAP: bounded hold time, optional early release, mandatory guard gap.
- Sits between the requester-detect logic (C1/C2-style inputs) and the resource sequencer.
- Produces a one-hot grant plus status for io_out mapping at the top level.

Parameters:
- HOLD_CYCLES, 8, maximum cycles a grant stays asserted; legal range 1..2**CW.
- GAP_CYCLES, 2, cycles with no grant after every release; legal range 1..2**CW.
- CW, 4, width of the internal down-counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  arbitration enable; low blocks new grants and forces release of an active grant.
- req  input  2  request per requester, level-sensitive; bit i = requester i.
- rel  input  2  early-release strobe per requester; only the bit of the current owner is honoured.
- gnt  output  2  one-hot grant, registered; 00 when no owner.
- busy  output  1  high in GRANT and GAP states, registered.
- owner  output  1  index of last/current granted requester, registered.
- timeout  output  1  one-cycle pulse when a grant ended by hold expiry, registered.

Behaviour:
- Reset: asynchronous. State=IDLE, gnt=00, busy=0, owner=0, timeout=0, cnt=0, priority pointer ptr=0 (requester 0 favoured).
- Reset mid-grant drops gnt immediately, without waiting for a clock edge.
- All outputs are driven from flops; no combinational input-to-output path.
- States: IDLE, GRANT, GAP (2-bit encoding). Unused encodings return to IDLE.
- IDLE:
  - gnt=00, busy=0.
  - If en=1 and req!=00 at a rising edge: choose the winner, go to GRANT, set gnt to the winner's one-hot, owner=winner, load cnt=HOLD_CYCLES-1.
  - Winner selection: if only one req bit is set, that requester wins; if both are set, the requester indexed by ptr wins.
  - Grant latency: a request sampled at edge N gives gnt high in the cycle after edge N.
- GRANT: exit conditions are evaluated each edge in this priority order.
  1. en=0 -> GAP, timeout=0.
  2. rel[owner]=1 or req[owner]=0 -> GAP, timeout=0.
  3. cnt==0 -> GAP, timeout=1 for exactly one cycle (the first GAP cycle).
  4. Otherwise cnt decrements and gnt holds.
  - On any exit: gnt=00, ptr=~owner, load cnt=GAP_CYCLES-1.
  - With req held and no release, gnt stays high for exactly HOLD_CYCLES cycles.
  - rel or req bits of the non-owner are ignored in GRANT.
- GAP:
  - gnt=00, busy=1.
  - If cnt==0 -> IDLE, else cnt decrements. The gap lasts exactly GAP_CYCLES cycles.
  - Requests are not sampled during GAP. The minimum gnt-low time between two grants is GAP_CYCLES+1 cycles.
- Fairness: with both requesters held continuously, grants alternate 0,1,0,1... each lasting HOLD_CYCLES cycles.
- Simultaneous events:
  - rel[owner] and cnt==0 on the same edge count as a release: timeout=0.
  - en falling in IDLE with a request pending: no grant is issued.
- Counter never wraps: it is reloaded on every state entry and only decremented while nonzero.

Test Plan:
1. HOLD=4, GAP=2. Assert rst mid-grant (gnt=01) between edges -> gnt=00, busy=0, owner=0 immediately. Release rst, req=00 -> outputs stay 0.
2. req=01 held from cycle 0 -> gnt=01 in cycles 1-4, timeout=1 in cycle 5, gnt=00 and busy=1 in cycles 5-6. IDLE in cycle 7, gnt=01 again in cycle 8.
3. req=11 held -> gnt sequence 01 (4 cycles), 00 (3 cycles), 10 (4 cycles), 00, 01; owner toggles 0,1,0.
4. req=10, then rel=10 pulsed in the 2nd grant cycle -> gnt=00 in the 3rd cycle, timeout=0, ptr favours requester 0. A following req=11 grants 01.
5. During a grant to requester 0, drive en=0 for one cycle -> gnt=00 next cycle, GAP of 2 cycles. With en low in IDLE and req=11 -> no grant until en=1.
6. Both requests present, rel[1] pulsed while requester 0 owns -> ignored, and the grant runs the full 4 cycles with timeout=1.

Source files
------------

// File: rtl/access_arbiter_fsm.sv
// Round-robin, time-limited arbiter sharing one resource between two requesters.
// Each grant runs IDLE -> GRANT -> GAP: bounded hold, optional early release, fixed guard gap.
module access_arbiter_fsm #(
   parameter int HOLD_CYCLES = 8,
   parameter int GAP_CYCLES  = 2,
   parameter int CW          = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [1:0] req,
   input  logic [1:0] rel,
   output logic [1:0] gnt,
   output logic       busy,
   output logic       owner,
   output logic       timeout,
   output logic [1:0] dbg_state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } state_t;

   localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LD  = CW'(GAP_CYCLES - 1);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          ptr_q, ptr_d;
   logic [1:0]    gnt_q, gnt_d;
   logic          busy_q, busy_d;
   logic          owner_q, owner_d;
   logic          timeout_q, timeout_d;
   logic          winner;
   logic          grant_exit;
   logic          hold_expired;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         ptr_q     <= 1'b0;
         gnt_q     <= 2'b00;
         busy_q    <= 1'b0;
         owner_q   <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ptr_q     <= ptr_d;
         gnt_q     <= gnt_d;
         busy_q    <= busy_d;
         owner_q   <= owner_d;
         timeout_q <= timeout_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ptr_d     = ptr_q;
      gnt_d     = gnt_q;
      busy_d    = busy_q;
      owner_d   = owner_q;
      timeout_d = 1'b0;
      // Ties go to the pointer; a lone request wins outright.
      winner       = (req == 2'b11) ? ptr_q : req[1];
      // Disable and release outrank expiry, so timeout only flags a pure hold expiry.
      hold_expired = en && !rel[owner_q] && req[owner_q] && (cnt_q == '0);
      grant_exit   = !en || rel[owner_q] || !req[owner_q] || (cnt_q == '0);

      case (state_q)
         IDLE: begin
            gnt_d  = 2'b00;
            busy_d = 1'b0;
            if (en && (req != 2'b00)) begin
               state_d = GRANT;
               gnt_d   = winner ? 2'b10 : 2'b01;
               owner_d = winner;
               busy_d  = 1'b1;
               cnt_d   = HOLD_LD;
            end
         end
         GRANT: begin
            busy_d = 1'b1;
            if (grant_exit) begin
               state_d   = GAP;
               gnt_d     = 2'b00;
               ptr_d     = ~owner_q;
               cnt_d     = GAP_LD;
               timeout_d = hold_expired;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         GAP: begin
            gnt_d  = 2'b00;
            busy_d = 1'b1;
            if (cnt_q == '0) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = 2'b00;
            busy_d  = 1'b0;
            cnt_d   = '0;
         end
      endcase
   end

   assign gnt       = gnt_q;
   assign busy      = busy_q;
   assign owner     = owner_q;
   assign timeout   = timeout_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_access_arbiter_fsm.sv
// Directed bench for access_arbiter_fsm with HOLD_CYCLES=4, GAP_CYCLES=2.
// Expected outputs are packed as {gnt, busy, owner, timeout}.
module tb_access_arbiter_fsm;

   logic       clk;
   logic       rst;
   logic       en;
   logic [1:0] req;
   logic [1:0] rel;
   logic [1:0] gnt;
   logic       busy;
   logic       owner;
   logic       timeout;
   logic [1:0] dbg_state;

   int n_vec;
   int n_err;
   logic [4:0] exp_q[$];

   access_arbiter_fsm #(
      .HOLD_CYCLES(4),
      .GAP_CYCLES (2),
      .CW         (4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .req      (req),
      .rel      (rel),
      .gnt      (gnt),
      .busy     (busy),
      .owner    (owner),
      .timeout  (timeout),
      .dbg_state(dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [4:0] outs();
      return {gnt, busy, owner, timeout};
   endfunction

   task automatic step_chk(input string tag, input logic [4:0] exp);
      @(posedge clk);
      #1;
      check(tag, {3'b000, outs()}, {3'b000, exp});
   endtask

   task automatic run_q(input string tag);
      while (exp_q.size() > 0) step_chk(tag, exp_q.pop_front());
   endtask

   task automatic do_reset();
      rst = 1'b1;
      en  = 1'b0;
      req = 2'b00;
      rel = 2'b00;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst = 1'b1;
      en  = 1'b0;
      req = 2'b00;
      rel = 2'b00;
      @(posedge clk);
      @(posedge clk);
      #1;
      check("reset_outs", {3'b000, outs()}, 8'h00);
      check("reset_state", {6'b0, dbg_state}, 8'h00);

      // 1: asynchronous reset in the middle of a grant
      rst = 1'b0;
      en  = 1'b1;
      req = 2'b01;
      step_chk("t1_grant", 5'b01100);
      #3;
      rst = 1'b1;
      #1;
      check("t1_async_rst", {3'b000, outs()}, 8'h00);
      check("t1_async_state", {6'b0, dbg_state}, 8'h00);
      @(posedge clk);
      #1;
      rst = 1'b0;
      req = 2'b00;
      step_chk("t1_idle_a", 5'b00000);
      step_chk("t1_idle_b", 5'b00000);

      // 1b: reset while requester 1 owns also clears owner
      req = 2'b10;
      step_chk("t1b_grant1", 5'b10110);
      #3;
      rst = 1'b1;
      #1;
      check("t1b_async_rst", {3'b000, outs()}, 8'h00);

      // 2: single requester held, hold expiry and regrant
      do_reset();
      en  = 1'b1;
      req = 2'b01;
      exp_q = '{5'b01100, 5'b01100, 5'b01100, 5'b01100,
                5'b00101, 5'b00100, 5'b00000, 5'b01100};
      run_q("t2_hold");
      req = 2'b00;
      step_chk("t2_drop_gap0", 5'b00100);
      check("t2_gap_state", {6'b0, dbg_state}, 8'h02);
      step_chk("t2_drop_gap1", 5'b00100);
      step_chk("t2_drop_idle", 5'b00000);

      // 3: both held, grants alternate
      do_reset();
      en  = 1'b1;
      req = 2'b11;
      exp_q = '{5'b01100, 5'b01100, 5'b01100, 5'b01100,
                5'b00101, 5'b00100, 5'b00000,
                5'b10110, 5'b10110, 5'b10110, 5'b10110,
                5'b00111, 5'b00110, 5'b00010, 5'b01100};
      run_q("t3_fair");

      // 4: early release by owner 1, pointer then favours 0
      do_reset();
      en  = 1'b1;
      req = 2'b10;
      step_chk("t4_g1", 5'b10110);
      step_chk("t4_g2", 5'b10110);
      rel = 2'b10;
      step_chk("t4_rel_gap", 5'b00110);
      rel = 2'b00;
      req = 2'b11;
      step_chk("t4_gap1", 5'b00110);
      step_chk("t4_idle", 5'b00010);
      step_chk("t4_regrant0", 5'b01100);

      // 5: en low aborts a grant; en low in IDLE blocks grants
      do_reset();
      en  = 1'b1;
      req = 2'b01;
      step_chk("t5_g1", 5'b01100);
      step_chk("t5_g2", 5'b01100);
      en = 1'b0;
      step_chk("t5_abort", 5'b00100);
      en = 1'b1;
      step_chk("t5_gap1", 5'b00100);
      en  = 1'b0;
      req = 2'b11;
      step_chk("t5_idle", 5'b00000);
      step_chk("t5_blocked_a", 5'b00000);
      step_chk("t5_blocked_b", 5'b00000);
      en = 1'b1;
      step_chk("t5_grant_ptr1", 5'b10110);

      // 6: non-owner release ignored, full hold with timeout
      do_reset();
      en  = 1'b1;
      req = 2'b11;
      step_chk("t6_g1", 5'b01100);
      rel = 2'b10;
      step_chk("t6_g2", 5'b01100);
      rel = 2'b00;
      step_chk("t6_g3", 5'b01100);
      step_chk("t6_g4", 5'b01100);
      step_chk("t6_timeout", 5'b00101);

      // 7: release on the expiry edge counts as release
      do_reset();
      en  = 1'b1;
      req = 2'b01;
      exp_q = '{5'b01100, 5'b01100, 5'b01100, 5'b01100};
      run_q("t7_hold");
      rel = 2'b01;
      step_chk("t7_rel_at_expiry", 5'b00100);
      rel = 2'b00;
      step_chk("t7_gap_pulse_clear", 5'b00100);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
